// File: rtl/bitty_issue_unit.sv
// bitty_issue_unit: instruction sequencer feeding a bitty_core.
// Holds a loadable program memory of 2**AW 16-bit words, issues one
// instruction at a time, and holds it until the core's done pulse.
// Optional feature macro: BITTY_ISSUE_BRANCH_EN (conditional skip of the
// next word when bit 15 is set and the core compare matches bits 14:13).
module bitty_issue_unit #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  output logic          busy,
  output logic          prog_done,
  output logic [15:0]   instruction,
  input  logic          core_done,
  input  logic [15:0]   core_result,
  input  logic [1:0]    core_compare,
  output logic [15:0]   last_result,
  output logic [AW:0]   exec_count,
  output logic [AW-1:0] pc
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    ARM    = 3'd2,
    WAIT   = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] mem [DEPTH];
  logic [AW:0] len_q;
  logic [AW:0] len_clamped;
  logic [AW:0] next_pc;
  logic        take_skip;
  logic        start_taken;

  // Requested lengths above the memory depth run the whole memory once.
  function automatic logic [AW:0] clamp_len(input logic [AW:0] len);
    return (len > DEPTH_V) ? DEPTH_V : len;
  endfunction

  // Length clamp and start qualification (a load in the same cycle wins).
  always_comb begin
    len_clamped = clamp_len(prog_len);
    start_taken = (state == IDLE) && start && !load_en;
  end

`ifdef BITTY_ISSUE_BRANCH_EN
  // Skip one word when the flagged compare code matches the core's compare.
  always_comb take_skip = instruction[15] && (core_compare == instruction[14:13]);
`else
  logic unused_compare;
  assign unused_compare = ^core_compare;
  // Without branch support the program always advances by one word.
  always_comb take_skip = 1'b0;
`endif

  // Next address is one bit wider than pc so running off the end never wraps.
  always_comb next_pc = {1'b0, pc} + (take_skip ? (AW + 1)'(2) : (AW + 1)'(1));

  // Program memory write port, only open while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && load_en) mem[load_addr] <= load_data;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; core_done seen during ARM belongs to the previous instruction.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_taken) state_nxt = (len_clamped == '0) ? FINISH : ISSUE;
      ISSUE:   state_nxt = ARM;
      ARM:     state_nxt = WAIT;
      WAIT:    if (core_done) state_nxt = (next_pc >= len_q) ? FINISH : ISSUE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy      = (state == ISSUE) || (state == ARM) || (state == WAIT);
    prog_done = (state == FINISH);
  end

  // Run bookkeeping, instruction register and captured core result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= '0;
      exec_count  <= '0;
      len_q       <= '0;
      instruction <= '0;
      last_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_taken && (len_clamped != '0)) begin
            pc         <= '0;
            exec_count <= '0;
            len_q      <= len_clamped;
          end
        end
        ISSUE: instruction <= mem[pc];
        WAIT: begin
          if (core_done) begin
            last_result <= core_result;
            exec_count  <= exec_count + (AW + 1)'(1);
            if (next_pc < len_q) pc <= next_pc[AW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitty_issue_unit.sv
// Testbench for bitty_issue_unit: randomized programs and core responses,
// scoreboard of expected issued instructions and run completions.
module tb_bitty_issue_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [15:0] load_data;
  logic        start;
  logic [4:0]  prog_len;
  logic        busy;
  logic        prog_done;
  logic [15:0] instruction;
  logic        core_done;
  logic [15:0] core_result;
  logic [1:0]  core_compare;
  logic [15:0] last_result;
  logic [4:0]  exec_count;
  logic [3:0]  pc;

  bitty_issue_unit #(.AW(4)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .prog_len(prog_len), .busy(busy),
    .prog_done(prog_done), .instruction(instruction), .core_done(core_done),
    .core_result(core_result), .core_compare(core_compare),
    .last_result(last_result), .exec_count(exec_count), .pc(pc)
  );

  always #5 clk = ~clk;

`ifdef BITTY_ISSUE_BRANCH_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  typedef struct {
    logic [15:0] last;
    logic [4:0]  cnt;
    logic [3:0]  pc;
  } comp_t;

  int          errors = 0;
  int          checks = 0;
  comp_t       exp_done_q[$];
  logic [15:0] exp_instr_q[$];
  logic [15:0] mdl_mem [16];
  logic [15:0] m_last = '0;
  logic [4:0]  m_cnt  = '0;
  logic [3:0]  m_pc   = '0;
  bit          in_wait = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  comp_t       mon_c;
  logic [15:0] mon_i;
  always @(negedge clk) begin
    if (!reset) begin
      if (core_done && in_wait) begin
        if (exp_instr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL instr_unexpected: got %0h expected none", instruction);
        end else begin
          mon_i = exp_instr_q.pop_front();
          check("instruction", instruction, mon_i);
          check("busy_in_wait", busy, 1);
        end
      end
      if (prog_done) begin
        if (exp_done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL prog_done_unexpected: got 1 expected 0");
        end else begin
          mon_c = exp_done_q.pop_front();
          check("last_result", last_result, mon_c.last);
          check("exec_count", exec_count, mon_c.cnt);
          check("pc_at_finish", pc, mon_c.pc);
          check("busy_at_finish", busy, 0);
        end
      end
    end
  end

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    mdl_mem[a] = d;
    step();
    load_en = 1'b0;
  endtask

  // One run: the bench acts as the core and computes the expected outcome.
  task automatic run(input int len, input bit inject, input bit glitch,
                     input bit rst_mid, input bit echo, input int cmp_force);
    int          len_eff, p, np, d;
    logic [15:0] r;
    logic [1:0]  cmp;
    bit          skip;
    comp_t       c;
    len_eff = (len > 16) ? 16 : len;
    start = 1'b1; prog_len = 5'(len);
    if (len_eff == 0) begin
      c.last = m_last; c.cnt = m_cnt; c.pc = m_pc;
      exp_done_q.push_back(c);
    end
    step();
    start = 1'b0;
    if (len_eff == 0) begin
      step();
      check("zero_len_done_seen", exp_done_q.size(), 0);
      return;
    end
    m_cnt = '0;
    p = 0;
    forever begin
      m_pc = 4'(p);
      exp_instr_q.push_back(mdl_mem[p]);
      step();                                  // now in ARM
      d = $urandom_range(0, 4);
      if (glitch && p == 0) begin
        core_done = 1'b1; core_result = 16'hDEAD; core_compare = 2'b11;
        d = 2;
      end
      step();                                  // now in first WAIT cycle
      core_done = 1'b0;
      if (rst_mid) begin
        reset = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_pc", pc, 0);
        check("rst_instruction", instruction, 0);
        check("rst_last_result", last_result, 0);
        check("rst_exec_count", exec_count, 0);
        m_last = '0; m_cnt = '0; m_pc = '0;
        exp_instr_q.delete();
        step();
        reset = 1'b0;
        step();
        return;
      end
      if (inject) begin
        start = 1'b1; prog_len = 5'd5;
        load_en = 1'b1; load_addr = 4'(p); load_data = ~mdl_mem[p];
        step();
        start = 1'b0; load_en = 1'b0;
      end
      repeat (d) step();
      r   = echo ? mdl_mem[p] : 16'($urandom);
      cmp = (cmp_force >= 0) ? 2'(cmp_force) : 2'($urandom);
      skip = BR && mdl_mem[p][15] && (cmp == mdl_mem[p][14:13]);
      np = p + (skip ? 2 : 1);
      m_last = r;
      m_cnt  = m_cnt + 5'd1;
      if (np >= len_eff) begin
        c.last = m_last; c.cnt = m_cnt; c.pc = m_pc;
        exp_done_q.push_back(c);
      end
      core_done = 1'b1; core_result = r; core_compare = cmp; in_wait = 1'b1;
      step();
      core_done = 1'b0; in_wait = 1'b0;
      if (np >= len_eff) break;
      p = np;
    end
    step();                                    // FINISH -> IDLE
    check("run_done_seen", exp_done_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; prog_len = '0; core_done = 1'b0; core_result = '0;
    core_compare = '0;
    #2;
    check("reset_busy", busy, 0);
    check("reset_prog_done", prog_done, 0);
    check("reset_instruction", instruction, 0);
    check("reset_last_result", last_result, 0);
    check("reset_exec_count", exec_count, 0);
    check("reset_pc", pc, 0);
    step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 16; i++) load(4'(i), 16'($urandom));

    // Basic three-word program with a core that echoes the instruction.
    load(4'd0, 16'h0000); load(4'd1, 16'h0000); load(4'd2, 16'h0004);
    run(3, 0, 0, 0, 1, -1);
    check("basic_last_result", last_result, 16'h0004);
    check("basic_exec_count", exec_count, 3);

    // Zero-length run.
    run(0, 0, 0, 0, 0, -1);

    // Load and start in the same cycle: load wins, no run starts.
    load_en = 1'b1; load_addr = 4'd5; load_data = 16'h1234; mdl_mem[5] = 16'h1234;
    start = 1'b1; prog_len = 5'd2;
    step();
    load_en = 1'b0; start = 1'b0;
    check("load_wins_busy", busy, 0);
    step();

    // Start and load while waiting are ignored; rerun shows old memory.
    run(3, 1, 0, 0, 0, -1);
    run(3, 0, 0, 0, 0, -1);

    // core_done in ARM is ignored, the later one completes the instruction.
    run(1, 0, 1, 0, 0, -1);
    check("glitch_exec_count", exec_count, 1);

    // Asynchronous reset mid-run, then a fresh run from address 0.
    run(3, 0, 0, 1, 0, -1);
    run(3, 0, 0, 0, 0, -1);

    // Flagged program: skips under the branch build, passes straight through otherwise.
    load(4'd0, 16'hE000); load(4'd1, 16'h0002); load(4'd2, 16'h0000);
    run(3, 0, 0, 0, 0, 3);
    check("branch_exec_count", exec_count, BR ? 2 : 3);

    // Randomized programs and lengths, including clamped lengths.
    for (int k = 0; k < 30; k++) begin
      for (int j = 0; j < 3; j++) load(4'($urandom), 16'($urandom));
      run($urandom_range(0, 31), 0, 0, 0, 0, -1);
    end
    run(16, 0, 0, 0, 0, -1);
    run(31, 0, 0, 0, 0, -1);

    repeat (3) step();
    check("instr_queue_empty", exp_instr_q.size(), 0);
    check("done_queue_empty", exp_done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
